alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational ALU instance among NREQ requesters, for example the execute stage, the branch-compare path and the address-generation unit. Each requester uses a valid/ready handshake. Grants are round-robin and rotate only on accepted requests. The ALU result is captured in a one-entry response register tagged with the requester ID. aluctrl codes are checked for legality before issue.

Parameters:
NREQ, 2, number of requesters; must be >= 2.
DATA_WIDTH, 32, operand and result width.
IDW, $clog2(NREQ), requester-ID width; derived, do not override.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
req_valid_i  in  NREQ  per-requester request valid.
req_ready_o  out  NREQ  per-requester accept; at most one bit set.
req_a_i  in  NREQ*DATA_WIDTH  operand A, requester i in slice [i*DATA_WIDTH +: DATA_WIDTH].
req_b_i  in  NREQ*DATA_WIDTH  operand B, packed as above.
req_ctrl_i  in  NREQ*4  aluctrl code, packed [i*4 +: 4].
alu_a_o  out  DATA_WIDTH  to ALU alu_a_i.
alu_b_o  out  DATA_WIDTH  to ALU alu_b_i.
aluctrl_ctrl_o  out  4  to ALU aluctrl_ctrl_i.
alu_out_i  in  DATA_WIDTH  from ALU alu_out_o; combinational, same cycle.
rsp_valid_o  out  1  response valid.
rsp_ready_i  in  1  response consumer accept.
rsp_id_o  out  IDW  requester index of the response.
rsp_data_o  out  DATA_WIDTH  registered ALU result.
rsp_err_o  out  1  request carried an illegal aluctrl code.

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous, active-high.
- Legal aluctrl codes:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011.
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - All other codes are illegal.
- State:
  - rr_ptr [IDW]: highest-priority index.
  - Response register: rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o.
- Reset values: rr_ptr=0, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rsp_err_o=0. While rst=1, req_ready_o=0.
- Arbitration (combinational):
  - Winner w is the first i with req_valid_i[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - No winner when no valid is asserted.
- Issue condition: can_issue = !rsp_valid_o || rsp_ready_i. This gives pass-through on drain: a new result may load in the same cycle the old one is consumed.
- Ready: req_ready_o[w] = can_issue && winner exists && !rst. All other bits are 0. req_ready_o may depend combinationally on req_valid_i and rsp_ready_i.
- ALU drive:
  - alu_a_o, alu_b_o and aluctrl_ctrl_o carry the winner's payload whenever a winner exists, regardless of can_issue.
  - With no winner, all three are driven to 0.
- Transfer: occurs when req_valid_i[w] && req_ready_o[w]. On the next edge:
  - rsp_valid_o <= 1.
  - rsp_id_o <= w.
  - Legal code: rsp_data_o <= alu_out_i, rsp_err_o <= 0.
  - Illegal code: rsp_data_o <= 0, rsp_err_o <= 1. The request is still consumed.
  - rr_ptr <= (w+1) mod NREQ.
- No transfer:
  - If rsp_valid_o && rsp_ready_i, then rsp_valid_o <= 0. Data, ID and error fields hold their last values.
  - Otherwise the response register holds.
  - rr_ptr holds.
- Latency: one cycle from transfer to rsp_valid_o. Throughput is one request per cycle when rsp_ready_i=1.
- Requester rules:
  - Once valid is asserted, a requester must hold valid and payload stable until ready.
  - The arbiter does not rely on this rule for correctness; it re-arbitrates every cycle.
- Fairness: under continuous contention each requester is granted within NREQ transfers.
- Response stability: while rsp_valid_o=1 and rsp_ready_i=0, all rsp_* outputs are stable.
- Reset mid-operation: a pending response is discarded (rsp_valid_o=0 at the next edge) and rr_ptr returns to 0. No request is accepted in any cycle where rst=1.
- Wrap-around: with rr_ptr=NREQ-1, the search order continues NREQ-1, 0, 1, ...
- ALU arithmetic: results are modulo 2^DATA_WIDTH, supplied by the ALU. The arbiter does not modify alu_out_i.

Test Plan:
1. Reset: rst=1 for 2 cycles with all req_valid_i=1 -> req_ready_o=0, rsp_valid_o=0. First cycle after release -> req_ready_o=01 (requester 0 wins, rr_ptr=0).
2. Single ADD: only req1 valid, a=5, b=7, ctrl=0000, rsp_ready_i=1 -> next cycle rsp_valid_o=1, rsp_id_o=1, rsp_data_o=12, rsp_err_o=0; rr_ptr=0.
3. Round-robin under contention: both requesters valid for 6 cycles, rsp_ready_i=1 -> response IDs 0,1,0,1,0,1, one per cycle, no idle cycle.
4. Backpressure: response pending, rsp_ready_i=0 for 3 cycles with req0 valid -> req_ready_o=00, rsp_* stable. rsp_ready_i=1 -> req0 accepted that cycle, new response next cycle.
5. Opcode checking:
   - ctrl=1111, a=3, b=4 -> rsp_err_o=1, rsp_data_o=0, requester consumed.
   - SRA, a=0x80000000, b=4, ctrl=1101 -> rsp_data_o=0xF8000000, rsp_err_o=0.
   - SUB, a=0, b=1, ctrl=1000 -> rsp_data_o=0xFFFFFFFF.
6. Reset mid-operation: rsp_valid_o=1 and rr_ptr=1, assert rst for 1 cycle -> rsp_valid_o=0 next edge. After release with both valid -> requester 0 granted first.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals of the shared-ALU arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 32
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]            req_valid_i;
  logic [NREQ-1:0]            req_ready_o;
  logic [NREQ*DATA_WIDTH-1:0] req_a_i;
  logic [NREQ*DATA_WIDTH-1:0] req_b_i;
  logic [NREQ*4-1:0]          req_ctrl_i;
  logic [DATA_WIDTH-1:0]      alu_a_o;
  logic [DATA_WIDTH-1:0]      alu_b_o;
  logic [3:0]                 aluctrl_ctrl_o;
  logic [DATA_WIDTH-1:0]      alu_out_i;
  logic                       rsp_valid_o;
  logic                       rsp_ready_i;
  logic [IDW-1:0]             rsp_id_o;
  logic [DATA_WIDTH-1:0]      rsp_data_o;
  logic                       rsp_err_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_ctrl_i, alu_out_i, rsp_ready_i,
    output req_ready_o, alu_a_o, alu_b_o, aluctrl_ctrl_o,
           rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_ctrl_i, alu_out_i, rsp_ready_i,
    input  req_ready_o, alu_a_o, alu_b_o, aluctrl_ctrl_o,
           rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters,
// with a one-entry tagged response register and aluctrl legality check.
module alu_arbiter #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  function automatic logic ctrl_legal(input logic [3:0] c);
    case (c)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: ctrl_legal = 1'b1;
      default:                                     ctrl_legal = 1'b0;
    endcase
  endfunction

  logic [IDW-1:0]        rr_ptr;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  logic [DATA_WIDTH-1:0] a_arr    [NREQ];
  logic [DATA_WIDTH-1:0] b_arr    [NREQ];
  logic [3:0]            ctrl_arr [NREQ];

  logic           found;
  logic [IDW-1:0] win;
  logic           can_issue;
  logic           xfer;
  logic [NREQ-1:0] ready;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i]    = bus.req_a_i[i*DATA_WIDTH +: DATA_WIDTH];
      b_arr[i]    = bus.req_b_i[i*DATA_WIDTH +: DATA_WIDTH];
      ctrl_arr[i] = bus.req_ctrl_i[i*4 +: 4];
    end
  end

  // Walk the search order backwards so the candidate closest to rr_ptr wins.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (bus.req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign can_issue = !rsp_valid || bus.rsp_ready_i;
  assign xfer      = found && can_issue && !rst;

  always_comb begin
    ready = '0;
    if (xfer) ready[win] = 1'b1;
  end

  assign bus.req_ready_o    = ready;
  assign bus.alu_a_o        = found ? a_arr[win]    : '0;
  assign bus.alu_b_o        = found ? b_arr[win]    : '0;
  assign bus.aluctrl_ctrl_o = found ? ctrl_arr[win] : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_id    <= win;
      // Illegal codes are still consumed, reported as an error with zero data.
      if (ctrl_legal(ctrl_arr[win])) begin
        rsp_data <= bus.alu_out_i;
        rsp_err  <= 1'b0;
      end else begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
      rr_ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    end else if (rsp_valid && bus.rsp_ready_i) begin
      rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_id_o    = rsp_id;
  assign bus.rsp_data_o  = rsp_data;
  assign bus.rsp_err_o   = rsp_err;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU on the shared port.
module tb_alu_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_arbiter_if #(.NREQ(2), .DATA_WIDTH(32)) bus ();

  alu_arbiter #(.NREQ(2), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU; illegal codes yield a marker value the arbiter must not pass.
  always_comb begin
    case (bus.aluctrl_ctrl_o)
      4'b0000: bus.alu_out_i = bus.alu_a_o + bus.alu_b_o;
      4'b1000: bus.alu_out_i = bus.alu_a_o - bus.alu_b_o;
      4'b0001: bus.alu_out_i = bus.alu_a_o << bus.alu_b_o[4:0];
      4'b0010: bus.alu_out_i = {31'd0, $signed(bus.alu_a_o) < $signed(bus.alu_b_o)};
      4'b0011: bus.alu_out_i = {31'd0, bus.alu_a_o < bus.alu_b_o};
      4'b0100: bus.alu_out_i = bus.alu_a_o ^ bus.alu_b_o;
      4'b0101: bus.alu_out_i = bus.alu_a_o >> bus.alu_b_o[4:0];
      4'b1101: bus.alu_out_i = $unsigned($signed(bus.alu_a_o) >>> bus.alu_b_o[4:0]);
      4'b0110: bus.alu_out_i = bus.alu_a_o | bus.alu_b_o;
      4'b0111: bus.alu_out_i = bus.alu_a_o & bus.alu_b_o;
      default: bus.alu_out_i = 32'hDEAD_BEEF;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    bus.req_a_i[i*32 +: 32]  = a;
    bus.req_b_i[i*32 +: 32]  = b;
    bus.req_ctrl_i[i*4 +: 4] = c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 1'b1;
    set_req(0, 32'd1, 32'd1, 4'b0000);
    set_req(1, 32'd2, 32'd2, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req_ready_o !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b exp 00", bus.req_ready_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", bus.rsp_valid_o); end
    checks++; if (bus.rsp_data_o !== 32'd0 || bus.rsp_id_o !== 1'b0 || bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_fields: got data %h id %b err %b exp 0/0/0", bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL release_ready: got %b exp 01", bus.req_ready_o); end
    bus.req_valid_i = 2'b00;
    #1;
    checks++; if (bus.alu_a_o !== 32'd0 || bus.aluctrl_ctrl_o !== 4'b0000) begin errors++; $display("FAIL idle_alu_drive: got a %h ctrl %b exp 0/0", bus.alu_a_o, bus.aluctrl_ctrl_o); end
    step();
  endtask

  task automatic test_single_add();
    set_req(1, 32'd5, 32'd7, 4'b0000);
    bus.req_valid_i = 2'b10;
    bus.rsp_ready_i = 1'b1;
    #1;
    checks++; if (bus.req_ready_o !== 2'b10) begin errors++; $display("FAIL add_ready: got %b exp 10", bus.req_ready_o); end
    step();
    bus.req_valid_i = 2'b00;
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b1) begin errors++; $display("FAIL add_rsp: got valid %b id %b exp 1/1", bus.rsp_valid_o, bus.rsp_id_o); end
    checks++; if (bus.rsp_data_o !== 32'd12 || bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL add_data: got %0d err %b exp 12/0", bus.rsp_data_o, bus.rsp_err_o); end
    bus.req_valid_i = 2'b11;
    #1;
    checks++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL add_ptr_wrap: got %b exp 01", bus.req_ready_o); end
    bus.req_valid_i = 2'b00;
    step();
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL add_drain: got %b exp 0", bus.rsp_valid_o); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_data;
    set_req(0, 32'd10, 32'd1, 4'b0000);
    set_req(1, 32'd20, 32'd2, 4'b1000);
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_data = (i % 2 == 0) ? 32'd11 : 32'd18;
      checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'(i % 2)) begin errors++; $display("FAIL rr_id[%0d]: got valid %b id %b exp 1/%0d", i, bus.rsp_valid_o, bus.rsp_id_o, i % 2); end
      checks++; if (bus.rsp_data_o !== exp_data) begin errors++; $display("FAIL rr_data[%0d]: got %0d exp %0d", i, bus.rsp_data_o, exp_data); end
    end
    bus.req_valid_i = 2'b00;
    step();
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b exp 0", bus.rsp_valid_o); end
  endtask

  task automatic test_backpressure();
    set_req(0, 32'd1, 32'd2, 4'b0000);
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 1'b0;
    step();
    set_req(0, 32'd100, 32'd23, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.req_ready_o !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b exp 00", i, bus.req_ready_o); end
      checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'd3 || bus.rsp_id_o !== 1'b0 || bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: got valid %b data %0d id %b err %b exp 1/3/0/0", i, bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o); end
      checks++; if (bus.alu_a_o !== 32'd100) begin errors++; $display("FAIL bp_alu_drive[%0d]: got %0d exp 100", i, bus.alu_a_o); end
      @(posedge clk);
    end
    #1;
    bus.rsp_ready_i = 1'b1;
    #1;
    checks++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL bp_passthru_ready: got %b exp 01", bus.req_ready_o); end
    step();
    bus.req_valid_i = 2'b00;
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'd123 || bus.rsp_id_o !== 1'b0) begin errors++; $display("FAIL bp_new_rsp: got valid %b data %0d id %b exp 1/123/0", bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o); end
    step();
  endtask

  task automatic test_opcodes();
    set_req(0, 32'd3, 32'd4, 4'b1111);
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 1'b1;
    #1;
    checks++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL illegal_consumed: got %b exp 01", bus.req_ready_o); end
    step();
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1 || bus.rsp_data_o !== 32'd0) begin errors++; $display("FAIL illegal_rsp: got valid %b err %b data %h exp 1/1/0", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o); end
    set_req(0, 32'h8000_0000, 32'd4, 4'b1101);
    step();
    checks++; if (bus.rsp_data_o !== 32'hF800_0000 || bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL sra: got %h err %b exp f8000000/0", bus.rsp_data_o, bus.rsp_err_o); end
    set_req(0, 32'd0, 32'd1, 4'b1000);
    step();
    checks++; if (bus.rsp_data_o !== 32'hFFFF_FFFF || bus.rsp_err_o !== 1'b0) begin errors++; $display("FAIL sub: got %h err %b exp ffffffff/0", bus.rsp_data_o, bus.rsp_err_o); end
    set_req(1, 32'd9, 32'd9, 4'b1001);
    bus.req_valid_i = 2'b10;
    step();
    checks++; if (bus.rsp_id_o !== 1'b1 || bus.rsp_err_o !== 1'b1 || bus.rsp_data_o !== 32'd0) begin errors++; $display("FAIL illegal_req1: got id %b err %b data %h exp 1/1/0", bus.rsp_id_o, bus.rsp_err_o, bus.rsp_data_o); end
    set_req(1, 32'h0000_00F0, 32'h0000_0F0F, 4'b0111);
    step();
    bus.req_valid_i = 2'b00;
    checks++; if (bus.rsp_data_o !== 32'h0000_0000 || bus.rsp_err_o !== 1'b0 || bus.rsp_id_o !== 1'b1) begin errors++; $display("FAIL and: got %h err %b id %b exp 0/0/1", bus.rsp_data_o, bus.rsp_err_o, bus.rsp_id_o); end
    step();
  endtask

  task automatic test_reset_mid();
    set_req(0, 32'd7, 32'd8, 4'b0000);
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 1'b0;
    step();
    bus.req_valid_i = 2'b00;
    checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b exp 1", bus.rsp_valid_o); end
    rst = 1'b1;
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 1'b1;
    #1;
    checks++; if (bus.req_ready_o !== 2'b00) begin errors++; $display("FAIL mid_rst_ready: got %b exp 00", bus.req_ready_o); end
    step();
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mid_discard: got %b exp 0", bus.rsp_valid_o); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready_o !== 2'b01) begin errors++; $display("FAIL mid_ptr_reset: got %b exp 01", bus.req_ready_o); end
    step();
    bus.req_valid_i = 2'b00;
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b0 || bus.rsp_data_o !== 32'd15) begin errors++; $display("FAIL mid_first_grant: got valid %b id %b data %0d exp 1/0/15", bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_data_o); end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid_i = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.req_ctrl_i  = '0;
    bus.rsp_ready_i = 1'b0;
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_opcodes();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
